writeback_unit: RTL and testbench
=================================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width.
REQ-003 Parameter FIFO_DEPTH, default 2, load-result buffer entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 alu_valid  input  1  ALU result present this cycle; no ready, always accepted.
REQ-007 alu_rd  input  ADDR_W  ALU destination register.
REQ-008 alu_data  input  DATA_W  ALU result.
REQ-009 mem_valid  input  1  load result offered.
REQ-010 mem_ready  output  1  load result can be accepted.
REQ-011 mem_rd  input  ADDR_W  load destination register.
REQ-012 mem_data  input  DATA_W  load data.
REQ-013 issue_valid  input  1  load issued this cycle; marks issue_rd outstanding.
REQ-014 issue_rd  input  ADDR_W  destination of issued load.
REQ-015 pending  output  2**ADDR_W  bitmap of registers with outstanding load.
REQ-016 reg_write  output  1  register-file write enable (registered).
REQ-017 rd  output  ADDR_W  register-file write index (registered).
REQ-018 write_data  output  DATA_W  register-file write data (registered).

Function
REQ-019 Single write port; at most one register write per cycle.
REQ-020 Load transfer occurs on edge where mem_valid && mem_ready; entry {mem_rd, mem_data} pushed to FIFO.
REQ-021 mem_ready = FIFO not full, from registered occupancy only; no combinational path from alu_valid or pop.
REQ-022 Full FIFO: mem_ready 0 even if a pop occurs same cycle; mem_valid held by producer.
REQ-023 Arbitration each cycle: alu_valid && alu_rd!=0 wins; else FIFO non-empty pops head; else idle.
REQ-024 ALU priority is strict; FIFO drains only on cycles without a qualifying ALU write.
REQ-025 alu_valid with alu_rd==0: dropped, no write, FIFO may pop that cycle.
REQ-026 ALU latency: alu_valid at edge k -> reg_write=1, rd=alu_rd, write_data=alu_data during cycle after edge k.
REQ-027 Load latency minimum 2: pushed at edge k, earliest pop at edge k+1, reg_write visible after k+1; no bypass around FIFO.
REQ-028 FIFO entries with rd==0 pop normally but produce reg_write=0.
REQ-029 FIFO order strictly preserved; pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-030 Idle cycle: reg_write=0; rd and write_data hold last value.
REQ-031 issue_valid && issue_rd!=0 sets pending[issue_rd] at edge.
REQ-032 Pop of entry with rd!=0 clears pending[rd] at pop edge.
REQ-033 Same-edge set and clear of same index: set wins.
REQ-034 ALU write never modifies pending; pending[0] always 0.

Reset
REQ-035 rst at edge: FIFO emptied, occupancy 0, pointers 0, pending all 0, reg_write 0, rd 0, write_data 0.
REQ-036 While rst high, all inputs ignored; in-flight FIFO contents discarded; mem_ready 1 on first cycle after rst falls.

Structure
REQ-037 Shared package holds DATA_W/ADDR_W constants and wb_entry_t {rd, data} record type.
REQ-038 Sub-module wb_fifo (synchronous FIFO, push/pop/full/empty/count) instantiated once for load results.

Verification
REQ-039 ALU only: alu_valid, alu_rd=5, alu_data=0xDEADBEEF -> next cycle reg_write=1, rd=5, write_data=0xDEADBEEF.
REQ-040 Load only: issue_rd=7; later mem_rd=7, mem_data=0x12345678 accepted edge k -> write after k+1, pending[7] 1->0 at pop.
REQ-041 Contention: loads to x1,x2 accepted while alu_valid continuous 4 cycles (rd=3) -> mem_ready 0 after 2 pushes, x1 then x2 written after ALU stops.
REQ-042 Zero register: alu_rd=0 and mem_rd=0 -> reg_write never 1; issue_rd=0 -> pending stays 0.
REQ-043 Set/clear race: pop of rd=9 on same edge as issue_rd=9 -> pending[9]=1 after edge.
REQ-044 Reset mid-operation: FIFO full, pending[4]=1, rst one cycle -> empty, pending 0, reg_write 0, mem_ready 1 next cycle.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared widths and the load-result record for the writeback unit
// Contents: WB_DATA_W / WB_ADDR_W default widths, wb_entry_t {rd, data}.
package writeback_unit_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO buffering load results ahead of the register-file write port
// Ports: clk, rst (sync, active-high); push/din write side; pop/dout read side (dout = head);
//        full, empty and count reflect registered occupancy only.
module wb_fifo
    import writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type T = wb_entry_t,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU results and buffered load results onto one register-file write port
// Ports: clk, rst (sync, active-high); alu_valid/alu_rd/alu_data (always accepted);
//        mem_valid/mem_ready/mem_rd/mem_data (load results, handshake); issue_valid/issue_rd
//        (load issue); pending (outstanding-load bitmap); reg_write/rd/write_data (registered write).
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_data,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_rd,
    output logic [2**ADDR_W-1:0] pending,
    output logic                 reg_write,
    output logic [ADDR_W-1:0]    rd,
    output logic [DATA_W-1:0]    write_data
);
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;
    entry_t head;
    logic full, empty, alu_win, pop, head_live;
    logic [$clog2(FIFO_DEPTH):0] count_unused;
    logic [2**ADDR_W-1:0] pending_next;
    wb_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(mem_valid && mem_ready),
        .din('{rd: mem_rd, data: mem_data}),
        .pop(pop),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count_unused)
    );
    assign mem_ready = !full;
    assign alu_win   = alu_valid && alu_rd != '0;
    assign pop       = !alu_win && !empty;
    assign head_live = pop && head.rd != '0;
    // a set from a new issue overrides a clear from a pop of the same register
    always_comb begin
        pending_next = pending;
        if (head_live) pending_next[head.rd] = 1'b0;
        if (issue_valid && issue_rd != '0) pending_next[issue_rd] = 1'b1;
    end
    // rd/write_data only move on a real write; dropped x0 traffic leaves them held
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            reg_write  <= 1'b0;
            rd         <= '0;
            write_data <= '0;
        end else begin
            pending   <= pending_next;
            reg_write <= alu_win || head_live;
            if (alu_win) begin
                rd         <= alu_rd;
                write_data <= alu_data;
            end else if (head_live) begin
                rd         <= head.rd;
                write_data <= head.data;
            end
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed self-checking bench for writeback_unit
module tb_writeback_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        alu_valid = 0;
    logic [4:0]  alu_rd = 0;
    logic [31:0] alu_data = 0;
    logic        mem_valid = 0;
    logic        mem_ready;
    logic [4:0]  mem_rd = 0;
    logic [31:0] mem_data = 0;
    logic        issue_valid = 0;
    logic [4:0]  issue_rd = 0;
    logic [31:0] pending;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    int n_cmp = 0;
    int n_bad = 0;

    writeback_unit dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .pending(pending),
        .reg_write(reg_write), .rd(rd), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string name, input logic we, input logic [4:0] erd, input logic [31:0] ed);
        n_cmp++;
        if (reg_write !== we || (we && (rd !== erd || write_data !== ed))) begin
            n_bad++;
            $display("FAIL %s: got we=%0b rd=%0d data=%h, want we=%0b rd=%0d data=%h", name, reg_write, rd, write_data, we, erd, ed);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        step();
        rst = 0;
        n_cmp++;
        if (reg_write !== 1'b0 || rd !== 5'd0 || write_data !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got we=%0b rd=%0d data=%h, want 0/0/0", reg_write, rd, write_data);
        end
        n_cmp++;
        if (pending !== 32'd0) begin n_bad++; $display("FAIL reset_pending: got %h want 0", pending); end
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", mem_ready); end
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 0;
        expect_wr("alu_write", 1, 5, 32'hDEADBEEF);
        step();
        n_cmp++;
        if (reg_write !== 1'b0 || rd !== 5'd5 || write_data !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL alu_idle_hold: got we=%0b rd=%0d data=%h, want 0/5/deadbeef", reg_write, rd, write_data);
        end
    endtask

    task automatic test_load();
        issue_valid = 1; issue_rd = 7;
        step();
        issue_valid = 0;
        n_cmp++;
        if (pending !== 32'h80) begin n_bad++; $display("FAIL load_pending_set: got %h want 00000080", pending); end
        mem_valid = 1; mem_rd = 7; mem_data = 32'h12345678;
        step();
        mem_valid = 0;
        expect_wr("load_no_bypass", 0, 0, 0);
        n_cmp++;
        if (pending !== 32'h80) begin n_bad++; $display("FAIL load_pending_held: got %h want 00000080", pending); end
        step();
        expect_wr("load_write", 1, 7, 32'h12345678);
        n_cmp++;
        if (pending !== 32'h0) begin n_bad++; $display("FAIL load_pending_clear: got %h want 0", pending); end
        step();
        expect_wr("load_after", 0, 0, 0);
    endtask

    task automatic test_contention();
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA0;
        mem_valid = 1; mem_rd = 1; mem_data = 32'h11;
        step();
        expect_wr("cont_alu0", 1, 3, 32'hA0);
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL cont_ready1: got %0b want 1", mem_ready); end
        alu_data = 32'hA1; mem_rd = 2; mem_data = 32'h22;
        step();
        expect_wr("cont_alu1", 1, 3, 32'hA1);
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL cont_full: got %0b want 0", mem_ready); end
        alu_data = 32'hA2; mem_rd = 10; mem_data = 32'h33;
        step();
        expect_wr("cont_alu2", 1, 3, 32'hA2);
        alu_data = 32'hA3;
        step();
        expect_wr("cont_alu3", 1, 3, 32'hA3);
        n_cmp++;
        if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL cont_still_full: got %0b want 0", mem_ready); end
        alu_valid = 0;
        step();
        expect_wr("cont_pop_x1", 1, 1, 32'h11);
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL cont_ready_after_pop: got %0b want 1", mem_ready); end
        step();
        mem_valid = 0;
        expect_wr("cont_pop_x2", 1, 2, 32'h22);
        step();
        expect_wr("cont_pop_x10", 1, 10, 32'h33);
        step();
        expect_wr("cont_drained", 0, 0, 0);
    endtask

    task automatic test_zero();
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
        mem_valid = 1; mem_rd = 0; mem_data = 32'h2;
        issue_valid = 1; issue_rd = 0;
        step();
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        expect_wr("zero_alu", 0, 0, 0);
        n_cmp++;
        if (pending !== 32'h0) begin n_bad++; $display("FAIL zero_pending: got %h want 0", pending); end
        step();
        expect_wr("zero_pop", 0, 0, 0);
        step();
        expect_wr("zero_after", 0, 0, 0);
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %0b want 1", mem_ready); end
    endtask

    task automatic test_race();
        issue_valid = 1; issue_rd = 9;
        step();
        issue_valid = 0;
        mem_valid = 1; mem_rd = 9; mem_data = 32'h99;
        step();
        mem_valid = 0;
        issue_valid = 1; issue_rd = 9;
        step();
        issue_valid = 0;
        expect_wr("race_write", 1, 9, 32'h99);
        n_cmp++;
        if (pending !== 32'h200) begin n_bad++; $display("FAIL race_set_wins: got %h want 00000200", pending); end
    endtask

    task automatic test_reset_mid();
        issue_valid = 1; issue_rd = 4;
        alu_valid = 1; alu_rd = 3; alu_data = 32'hB0;
        mem_valid = 1; mem_rd = 4; mem_data = 32'h44;
        step();
        issue_valid = 0;
        mem_rd = 6; mem_data = 32'h66;
        step();
        n_cmp++;
        if (mem_ready !== 1'b0 || pending[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_setup: got ready=%0b pending=%h, want ready=0 pending[4]=1", mem_ready, pending);
        end
        rst = 1; issue_valid = 1; issue_rd = 8;
        step();
        rst = 0; alu_valid = 0; mem_valid = 0; issue_valid = 0;
        n_cmp++;
        if (reg_write !== 1'b0 || rd !== 5'd0 || write_data !== 32'd0 || pending !== 32'd0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got we=%0b rd=%0d data=%h pending=%h, want all 0", reg_write, rd, write_data, pending);
        end
        n_cmp++;
        if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %0b want 1", mem_ready); end
        step();
        expect_wr("mid_discarded", 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_contention();
        test_zero();
        test_race();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
